// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges in-order pipeline writebacks (port A) and buffered long-latency
// results (port B) onto the single register-file write port. Define RF_WB_FWD_EN for the lookup.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        a_valid_i,
  input  logic [4:0]  a_rd_i,
  input  logic [31:0] a_data_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic [4:0]  b_rd_i,
  input  logic [31:0] b_data_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        we3_o,
  output logic [4:0]  a3_o,
  output logic [31:0] wd3_o
`ifdef RF_WB_FWD_EN
  ,
  input  logic [4:0]  fwd_a1_i,
  input  logic [4:0]  fwd_a2_i,
  output logic        fwd_hit1_o,
  output logic        fwd_hit2_o,
  output logic [31:0] fwd_data1_o,
  output logic [31:0] fwd_data2_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        kill;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;

  logic   live_a, head_vld, head_live, push, pop, b_wins;
  entry_t head;

  // Flags come from stored occupancy only, so b_ready_o never depends on b_valid_i.
  assign b_ready_o = (count_q != FULL_CNT);
  assign busy_o    = (count_q != '0);
  assign stall_o   = stall_q;
  assign we3_o     = we3_q;
  assign a3_o      = a3_q;
  assign wd3_o     = wd3_q;

  always_comb begin
    // NOTE: every variable gets a value before any conditional logic, so no latch can be inferred.
    live_a    = a_valid_i && (a_rd_i != 5'd0);
    head      = ent_q[rd_ptr_q];
    head_vld  = (count_q != '0);
    head_live = head_vld && !head.kill;
    push      = b_valid_i && b_ready_o;
    b_wins    = head_live && !live_a;
    // A killed head leaves even while A owns the port; a live one only when it writes.
    pop       = head_vld && (head.kill || !live_a);

    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_a && (ent_q[i].rd == a_rd_i)) ent_d[i].kill = 1'b1;
    end
    if (push) begin
      ent_d[wr_ptr_q] = '{kill: (b_rd_i == 5'd0) || (live_a && (a_rd_i == b_rd_i)),
                          rd:   b_rd_i,
                          data: b_data_i};
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    if (!head_vld || pop)          starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
    else                           starve_d = starve_q;
    stall_d = (starve_d == STARVE_MAX);

    we3_d = live_a || b_wins;
    a3_d  = '0;
    wd3_d = '0;
    if (live_a) begin
      a3_d  = a_rd_i;
      wd3_d = a_data_i;
    end else if (b_wins) begin
      a3_d  = head.rd;
      wd3_d = head.data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  // NOTE: the entry storage has no reset; clearing count_q makes every slot invalid.
  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

`ifdef RF_WB_FWD_EN
  // The output register is checked first, then buffered entries; newest live match wins.
  function automatic logic [32:0] fwd_lookup(input logic [4:0] addr);
    logic             hit;
    logic [31:0]      data;
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && !ent_q[idx].kill && (ent_q[idx].rd == addr)) begin
        hit  = 1'b1;
        data = ent_q[idx].data;
      end
    end
    if (we3_q && (a3_q == addr)) begin
      hit  = 1'b1;
      data = wd3_q;
    end
    if (addr == 5'd0) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {fwd_hit1_o, fwd_data1_o} = fwd_lookup(fwd_a1_i);
    {fwd_hit2_o, fwd_data2_o} = fwd_lookup(fwd_a2_i);
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, reset/forwarding
// sequences, then randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        a_valid_i = 1'b0;
  logic [4:0]  a_rd_i = '0;
  logic [31:0] a_data_i = '0;
  logic        b_valid_i = 1'b0;
  logic [4:0]  b_rd_i = '0;
  logic [31:0] b_data_i = '0;
  logic        b_ready_o, stall_o, busy_o, we3_o;
  logic [4:0]  a3_o;
  logic [31:0] wd3_o;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_a1_i = '0;
  logic [4:0]  fwd_a2_i = '0;
  logic        fwd_hit1_o, fwd_hit2_o;
  logic [31:0] fwd_data1_o, fwd_data2_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_rd_i(b_rd_i), .b_data_i(b_data_i),
    .stall_o(stall_o), .busy_o(busy_o),
    .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_a1_i(fwd_a1_i), .fwd_a2_i(fwd_a2_i),
    .fwd_hit1_o(fwd_hit1_o), .fwd_hit2_o(fwd_hit2_o),
    .fwd_data1_o(fwd_data1_o), .fwd_data2_o(fwd_data2_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an in-order queue of pending B results plus expected port state.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_we = 0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  bit          m_stall = 0;

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_stall = 0;
  endtask

  task automatic model_step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                            input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    bit   live_a;
    bit   push;
    bit   popped;
    bit   was_empty;
    ent_t h;
    live_a    = av && (ard != 0);
    push      = bv && (mq.size() < DEPTH);
    was_empty = (mq.size() == 0);
    popped    = 0;
    m_we = 0; m_a3 = '0; m_wd = '0;
    if (live_a) begin
      m_we = 1; m_a3 = ard; m_wd = ad;
    end
    if (!was_empty) begin
      if (mq[0].kill) begin
        h = mq.pop_front();
        popped = 1;
      end else if (!live_a) begin
        h = mq.pop_front();
        popped = 1;
        m_we = 1; m_a3 = h.rd; m_wd = h.data;
      end
    end
    if (was_empty || popped) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (live_a) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].kill = 1;
    end
    if (push) mq.push_back('{rd: brd, data: bd, kill: (brd == 0) || (live_a && ard == brd)});
    m_stall = (m_starve == LIMIT);
  endtask

  task automatic m_fwd(input logic [4:0] addr, output bit hit, output logic [31:0] data);
    hit = 0; data = '0;
    if (addr != 0) begin
      if (m_we && m_a3 == addr) begin
        hit = 1; data = m_wd;
      end else begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!hit && !mq[i].kill && mq[i].rd == addr) begin
            hit = 1; data = mq[i].data;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    a_valid_i = av; a_rd_i = ard; a_data_i = ad;
    b_valid_i = bv; b_rd_i = brd; b_data_i = bd;
  endtask

  // One clock with model prediction; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    drive(av, ard, ad, bv, brd, bd);
    model_step(av, ard, ad, bv, brd, bd);
    @(posedge clk);
    #1;
    check("m_we3",   32'(we3_o),     32'(m_we));
    check("m_a3",    32'(a3_o),      32'(m_a3));
    check("m_wd3",   wd3_o,          m_wd);
    check("m_stall", 32'(stall_o),   32'(m_stall));
    check("m_busy",  32'(busy_o),    32'(mq.size() != 0));
    check("m_ready", 32'(b_ready_o), 32'(mq.size() < DEPTH));
  endtask

  typedef struct {
    bit          av;
    logic [4:0]  ard;
    logic [31:0] ad;
    bit          bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    bit          we;
    logic [4:0]  a3;
    logic [31:0] wd;
    bit          busy;
    bit          rdy;
    bit          stall;
  } vec_t;

  function automatic vec_t mk(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                              input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                              input bit we, input logic [4:0] a3, input logic [31:0] wd,
                              input bit busy, input bit rdy, input bit stall);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
    v.we = we; v.a3 = a3; v.wd = wd; v.busy = busy; v.rdy = rdy; v.stall = stall;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    bit          eh;
    logic [31:0] ed;

    //                av ard  ad            bv brd  bd              we a3  wd            bsy rdy stl
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,             1, 5,  32'hDEADBEEF, 0, 1, 0);
    vecs[1]  = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[2]  = mk(0, 0,  0,            1, 7,  32'h11,        0, 0,  0,            1, 1, 0);
    vecs[3]  = mk(0, 0,  0,            0, 0,  0,             1, 7,  32'h11,       0, 1, 0);
    vecs[4]  = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[5]  = mk(0, 0,  0,            1, 9,  32'h99,        0, 0,  0,            1, 1, 0);
    vecs[6]  = mk(1, 9,  32'hA9,       0, 0,  0,             1, 9,  32'hA9,       1, 1, 0);
    vecs[7]  = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[8]  = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[9]  = mk(1, 1,  32'h1,        1, 10, 32'hB0B00010,  1, 1,  32'h1,        1, 1, 0);
    vecs[10] = mk(1, 2,  32'h2,        1, 11, 32'hB0B00011,  1, 2,  32'h2,        1, 0, 0);
    vecs[11] = mk(1, 3,  32'h3,        0, 0,  0,             1, 3,  32'h3,        1, 0, 0);
    vecs[12] = mk(1, 4,  32'h4,        0, 0,  0,             1, 4,  32'h4,        1, 0, 0);
    vecs[13] = mk(1, 6,  32'h6,        0, 0,  0,             1, 6,  32'h6,        1, 0, 1);
    vecs[14] = mk(0, 0,  0,            0, 0,  0,             1, 10, 32'hB0B00010, 1, 1, 0);
    vecs[15] = mk(0, 0,  0,            0, 0,  0,             1, 11, 32'hB0B00011, 0, 1, 0);
    vecs[16] = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[17] = mk(1, 0,  32'h66,       1, 0,  32'h55,        0, 0,  0,            1, 1, 0);
    vecs[18] = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[19] = mk(1, 12, 32'hC,        1, 12, 32'hD,         1, 12, 32'hC,        1, 1, 0);
    vecs[20] = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);
    vecs[21] = mk(0, 0,  0,            0, 0,  0,             0, 0,  0,            0, 1, 0);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_we3",   32'(we3_o),     32'h0);
    check("rst_a3",    32'(a3_o),      32'h0);
    check("rst_wd3",   wd3_o,          32'h0);
    check("rst_stall", 32'(stall_o),   32'h0);
    check("rst_busy",  32'(busy_o),    32'h0);
    check("rst_ready", 32'(b_ready_o), 32'h1);
`ifdef RF_WB_FWD_EN
    fwd_a1_i = 5'd5; fwd_a2_i = 5'd0;
    #1;
    check("rst_fwd_hit1",  32'(fwd_hit1_o), 32'h0);
    check("rst_fwd_data1", fwd_data1_o,     32'h0);
    check("rst_fwd_hit2",  32'(fwd_hit2_o), 32'h0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();

    // Directed vectors.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd);
      model_step(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we3", i),   32'(we3_o),     32'(vecs[i].we));
      check($sformatf("v%0d_a3", i),    32'(a3_o),      32'(vecs[i].a3));
      check($sformatf("v%0d_wd3", i),   wd3_o,          vecs[i].wd);
      check($sformatf("v%0d_busy", i),  32'(busy_o),    32'(vecs[i].busy));
      check($sformatf("v%0d_ready", i), 32'(b_ready_o), 32'(vecs[i].rdy));
      check($sformatf("v%0d_stall", i), 32'(stall_o),   32'(vecs[i].stall));
    end

`ifdef RF_WB_FWD_EN
    // Two buffered writes to rd 3; the newer one must be forwarded.
    step(1, 20, 32'hAAAA0020, 1, 3, 32'h1);
    step(1, 20, 32'hAAAA0021, 1, 3, 32'h2);
    fwd_a1_i = 5'd3; fwd_a2_i = 5'd0;
    #1;
    check("fwd_newest_hit",  32'(fwd_hit1_o), 32'h1);
    check("fwd_newest_data", fwd_data1_o,     32'h2);
    check("fwd_x0_hit",      32'(fwd_hit2_o), 32'h0);
    check("fwd_x0_data",     fwd_data2_o,     32'h0);
    fwd_a1_i = 5'd20;
    #1;
    check("fwd_outreg_data", fwd_data1_o, 32'hAAAA0021);
    step(0, 0, 0, 0, 0, 0);
    fwd_a1_i = 5'd3;
    #1;
    check("fwd_outreg_first", fwd_data1_o, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`endif

    // Reset in the middle of a blocked, full buffer.
    step(1, 1, 32'h101, 1, 20, 32'h20);
    step(1, 2, 32'h102, 1, 21, 32'h21);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_we3",   32'(we3_o),     32'h0);
    check("midrst_busy",  32'(busy_o),    32'h0);
    check("midrst_ready", 32'(b_ready_o), 32'h1);
    check("midrst_stall", 32'(stall_o),   32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    check("postrst_no_write", 32'(we3_o), 32'h0);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
`ifdef RF_WB_FWD_EN
      fwd_a1_i = 5'($urandom_range(0, 7));
      fwd_a2_i = 5'($urandom_range(0, 7));
      #1;
      m_fwd(fwd_a1_i, eh, ed);
      check("rnd_fwd_hit1",  32'(fwd_hit1_o), 32'(eh));
      check("rnd_fwd_data1", fwd_data1_o,     ed);
      m_fwd(fwd_a2_i, eh, ed);
      check("rnd_fwd_hit2",  32'(fwd_hit2_o), 32'(eh));
      check("rnd_fwd_data2", fwd_data2_o,     ed);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Writer end of the single register-file write port. Merges in-order pipeline writebacks (port A) and out-of-order results from long-latency units such as the divider and load-miss path (port B) onto one write port.

- Port B results are held in a small FIFO.
- Stale buffered results are suppressed when a younger pipeline write targets the same register.
- The registered outputs drive the register file, which commits on the falling edge of the same cycle.

## Interface

Parameters:

- DEPTH, 2 – port-B buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4 – consecutive blocked cycles of a live B head before a pipeline stall is requested; 1..15.

Ports:

- clk_i input 1 – the block's one clock; all state updates on its rising edge.
- rst_ni input 1 – reset, asynchronous, active-low.
- a_valid_i input 1 – pipeline writeback valid; no back-pressure.
- a_rd_i input 5 – pipeline destination register.
- a_data_i input 32 – pipeline result.
- b_valid_i input 1 – long-latency result valid.
- b_ready_o output 1 – buffer can accept; high when fewer than DEPTH entries are held.
- b_rd_i input 5 – long-latency destination register.
- b_data_i input 32 – long-latency result.
- stall_o output 1 – request that the pipeline hold port A idle.
- busy_o output 1 – buffer non-empty.
- we3_o output 1 – register-file write enable.
- a3_o output 5 – register-file write address.
- wd3_o output 32 – register-file write data.
- fwd_a1_i / fwd_a2_i input 5 – forwarding lookup addresses (RF_WB_FWD_EN only).
- fwd_hit1_o / fwd_hit2_o output 1 – lookup hit (RF_WB_FWD_EN only).
- fwd_data1_o / fwd_data2_o output 32 – forwarded data (RF_WB_FWD_EN only).

## Operation

- **B accept:** B transfers on b_valid_i && b_ready_o. b_ready_o depends only on stored state, never on b_valid_i.
- **Entry contents:** each entry holds rd, data and a kill bit.
- **Live A write:** a_valid_i && a_rd_i≠0.
- **Kill rule:** a live A write sets the kill bit of every buffered entry whose rd equals a_rd_i. It also kills a B entry accepted in the same cycle with the same rd.
- **x0 entries:** B entries with rd=0 are accepted with the kill bit set.
- **Per-cycle selection, in priority order:**
  1. A live A write drives the write port.
  2. Otherwise, a live (unkilled) B head drives the write port and pops.
  3. Otherwise the write port is idle.
- **Killed head:** pops in any cycle, including cycles where A owns the port. It never writes.
- **Push and pop together:** allowed in the same cycle; the occupancy count is unchanged.
- **Starvation counter:**
  - Increments in each cycle where a live B head exists and a live A write wins.
  - Clears when the head pops or the buffer is empty.
  - Saturates at STARVE_LIMIT.
- **stall_o:** registered; high while counter == STARVE_LIMIT.
  - Pipeline contract: a_valid_i is low in every cycle that stall_o is high.
  - If a_valid_i is high anyway, A still wins; no data is lost and stall_o stays high.
- **busy_o:** high when count ≠ 0.

## Timing

- **Reset values:**
  - we3_o=0, a3_o=0, wd3_o=0.
  - stall_o=0, busy_o=0, b_ready_o=1.
  - Buffer empty, counter 0.
  - fwd outputs 0.
- **Reset mid-operation:** discards all buffered entries immediately; no write is issued.
- **Write latency:**
  - Port A input at edge N appears on we3_o/a3_o/wd3_o after edge N, for exactly one cycle. The register file commits it at that cycle's falling edge.
  - Port B minimum latency: accepted at edge N, written at edge N+1 output if unblocked.
- **Buffer flags:**
  - Full: b_ready_o=0 the cycle after the count reaches DEPTH.
  - A pop in that cycle raises b_ready_o the following cycle; there is no same-cycle pass-through.
- **Pointer wrap:** read/write pointers wrap modulo DEPTH.

## Configuration

- **RF_WB_FWD_EN defined:** fwd ports exist and are combinational.
  - Sources are searched in this order: the output register if we3_o and a3_o match, then buffer entries from newest to oldest, skipping killed entries. The first match wins.
  - Address 0 never hits.
- **RF_WB_FWD_EN undefined:** fwd ports and lookup logic are absent. All other behaviour is identical.

## Test plan

- Reset, then A writes rd=5, data=0xDEADBEEF -> next cycle we3_o=1, a3_o=5, wd3_o=0xDEADBEEF; following cycle we3_o=0.
- B pushes rd=7, data=0x11 while A is idle -> written one cycle later; busy_o pulses for 1 cycle.
- B pushes rd=9, then A writes rd=9 before the drain -> only the A value reaches rd 9; the B entry pops with no write.
- B pushes DEPTH entries while A is valid every cycle -> b_ready_o=0 once full; stall_o=1 after 4 blocked cycles. With A then idle, entries drain in FIFO order and stall_o clears.
- B pushes rd=0, and A writes rd=0 -> we3_o never asserts; handshakes complete.
- RF_WB_FWD_EN: buffer holds rd=3 data=0x1 and rd=3 data=0x2 (newer) -> fwd_a1_i=3 gives hit=1, data=0x2. fwd_a1_i=0 gives hit=0.
